// File: rtl/entrada_digitos.sv
// Digit-entry front end: debounces confirm/back keys and writes switch codes into digit registers.
// Optional REJEITA_REPETIDO_EN: also reject a confirm whose code repeats an already-filled digit.
module entrada_digitos #(
    parameter int unsigned NUM_DIGITOS     = 4,
    parameter int unsigned VALOR_MAX       = 9,
    parameter int unsigned DEBOUNCE_CICLOS = 1_000_000,
    parameter int unsigned CNT_BITS        = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               switchCod,
    input  logic                     btnConfirma,
    input  logic                     btnVolta,
    output logic [2:0]               estadoJogo,
    output logic [4*NUM_DIGITOS-1:0] registradores,
    output logic                     completo,
    output logic                     erro
);

    localparam logic [2:0]          ULTIMO  = 3'(NUM_DIGITOS);
    localparam logic [CNT_BITS-1:0] CNT_FIM = CNT_BITS'(DEBOUNCE_CICLOS - 1);

    typedef enum logic {StEdita, StFim} estado_t;

    estado_t             estado;
    logic [1:0]          btn_bruto;
    logic [1:0]          sinc1, sinc2, deb, deb_ant, armado;
    logic [CNT_BITS-1:0] cnt [2];
    logic [1:0]          pulso;
    logic                p_conf, p_volta;
    logic                aceito, repetido;

    // Bit 0 is confirm, bit 1 is back; both active-low.
    assign btn_bruto = {btnVolta, btnConfirma};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sinc1   <= '0;
            sinc2   <= '0;
            deb     <= '1;
            deb_ant <= '1;
            armado  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sinc1   <= btn_bruto;
            sinc2   <= sinc1;
            deb_ant <= deb;
            // A key held through reset must be seen released before it can pulse.
            armado  <= armado | sinc2;
            for (int i = 0; i < 2; i++) begin
                if (sinc2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_FIM) begin
                    deb[i] <= sinc2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulso   = armado & deb_ant & ~deb;
    assign p_conf  = pulso[0];
    assign p_volta = pulso[1];

    always_comb begin
        repetido = 1'b0;
`ifdef REJEITA_REPETIDO_EN
        for (int unsigned i = 0; i < NUM_DIGITOS; i++) begin
            if (i < 32'(estadoJogo) && registradores[4*i +: 4] == switchCod) repetido = 1'b1;
        end
`endif
        aceito = (switchCod != 4'd0) && ({28'd0, switchCod} <= VALOR_MAX) && !repetido;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado        <= StEdita;
            estadoJogo    <= '0;
            registradores <= '0;
            completo      <= 1'b0;
            erro          <= 1'b0;
        end else begin
            erro <= 1'b0;
            unique case (estado)
                StEdita: begin
                    if (p_conf && !p_volta) begin
                        if (aceito) begin
                            registradores[4*32'(estadoJogo) +: 4] <= switchCod;
                            estadoJogo <= estadoJogo + 3'd1;
                            if (estadoJogo + 3'd1 == ULTIMO) begin
                                estado   <= StFim;
                                completo <= 1'b1;
                            end
                        end else begin
                            erro <= 1'b1;
                        end
                    end else if (p_volta && !p_conf && estadoJogo != 3'd0) begin
                        estadoJogo <= estadoJogo - 3'd1;
                        registradores[4*(32'(estadoJogo) - 1) +: 4] <= 4'd0;
                    end
                end
                StFim: begin
                    if (p_volta && !p_conf) begin
                        estado     <= StEdita;
                        estadoJogo <= ULTIMO - 3'd1;
                        registradores[4*(NUM_DIGITOS-1) +: 4] <= 4'd0;
                        completo   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entrada_digitos.sv
// Bench for entrada_digitos: directed vector table, multi-cycle corner cases, random key sequences.
module tb_entrada_digitos;

    localparam int N    = 4;
    localparam int VMAX = 9;
    localparam int D    = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  switchCod;
    logic        btnConfirma, btnVolta;
    logic [2:0]  estadoJogo;
    logic [15:0] registradores;
    logic        completo, erro;

    always #5 clk = ~clk;

    entrada_digitos #(
        .NUM_DIGITOS    (N),
        .VALOR_MAX      (VMAX),
        .DEBOUNCE_CICLOS(D),
        .CNT_BITS       (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .switchCod    (switchCod),
        .btnConfirma  (btnConfirma),
        .btnVolta     (btnVolta),
        .estadoJogo   (estadoJogo),
        .registradores(registradores),
        .completo     (completo),
        .erro         (erro)
    );

    int   total = 0, passed = 0;
    int   erro_cnt = 0, erro_long = 0;
    logic erro_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n && erro) erro_cnt <= erro_cnt + 1;
        if (erro && erro_prev) erro_long <= erro_long + 1;
        erro_prev <= erro;
    end

    // Reference model: one accepted key press = one edit operation.
    int m_est;
    int m_regs [N];
    int m_err = 0;

    function automatic void model_reset();
        m_est = 0;
        for (int i = 0; i < N; i++) m_regs[i] = 0;
    endfunction

    function automatic void model_conf(int v);
        bit rej;
        if (m_est == N) return;
        rej = (v < 1) || (v > VMAX);
`ifdef REJEITA_REPETIDO_EN
        for (int i = 0; i < m_est; i++) if (m_regs[i] == v) rej = 1'b1;
`endif
        if (rej) m_err++;
        else begin
            m_regs[m_est] = v;
            m_est++;
        end
    endfunction

    function automatic void model_volta();
        if (m_est == N) begin
            m_est = N - 1;
            m_regs[N-1] = 0;
        end else if (m_est > 0) begin
            m_est--;
            m_regs[m_est] = 0;
        end
    endfunction

    function automatic logic [15:0] model_packed();
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) r = r | (16'(m_regs[i]) << (4 * i));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit conf, input bit volta, input logic [3:0] v);
        switchCod = v;
        if (conf) btnConfirma = 1'b0;
        if (volta) btnVolta = 1'b0;
        cycles(10);
        btnConfirma = 1'b1;
        btnVolta    = 1'b1;
        cycles(10);
    endtask

    task automatic bounce_conf(input logic [3:0] v, input bit random_len);
        int segs;
        segs = random_len ? int'($urandom_range(2, 7)) : 6;
        switchCod = v;
        for (int k = 0; k < segs; k++) begin
            btnConfirma = (k % 2 == 0) ? 1'b0 : 1'b1;
            cycles(random_len ? int'($urandom_range(1, 3)) : 2);
        end
        btnConfirma = 1'b0;
        cycles(10);
        btnConfirma = 1'b1;
        cycles(10);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_est"}, 32'(estadoJogo), 32'(m_est));
        check({tag, "_regs"}, 32'(registradores), 32'(model_packed()));
        check({tag, "_completo"}, 32'(completo), 32'(m_est == N));
        check({tag, "_erro_cnt"}, 32'(erro_cnt), 32'(m_err));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        model_reset();
    endtask

    typedef struct {
        int          op;   // 0 confirm, 1 back, 2 both together
        logic [3:0]  sw;
        int          est;
        logic [15:0] regs;
        int          errs;
    } vec_t;

    vec_t tab [17];

    initial begin
        int n;
        int r;
        logic [3:0] v;

        tab[0]  = '{0, 4'd3,  1, 16'h0003, 0};
        tab[1]  = '{1, 4'd0,  0, 16'h0000, 0};
        tab[2]  = '{1, 4'd0,  0, 16'h0000, 0};
        tab[3]  = '{0, 4'd0,  0, 16'h0000, 1};
        tab[4]  = '{0, 4'd10, 0, 16'h0000, 2};
        tab[5]  = '{0, 4'd1,  1, 16'h0001, 2};
        tab[6]  = '{0, 4'd2,  2, 16'h0021, 2};
        tab[7]  = '{0, 4'd3,  3, 16'h0321, 2};
        tab[8]  = '{0, 4'd4,  4, 16'h4321, 2};
        tab[9]  = '{0, 4'd5,  4, 16'h4321, 2};
        tab[10] = '{1, 4'd0,  3, 16'h0321, 2};
        tab[11] = '{2, 4'd7,  3, 16'h0321, 2};
        tab[12] = '{1, 4'd0,  2, 16'h0021, 2};
        tab[13] = '{1, 4'd0,  1, 16'h0001, 2};
        tab[14] = '{1, 4'd0,  0, 16'h0000, 2};
        tab[15] = '{0, 4'd5,  1, 16'h0005, 2};
`ifdef REJEITA_REPETIDO_EN
        tab[16] = '{0, 4'd5,  1, 16'h0005, 3};
`else
        tab[16] = '{0, 4'd5,  2, 16'h0055, 2};
`endif

        reset_n     = 1'b0;
        switchCod   = 4'd0;
        btnConfirma = 1'b1;
        btnVolta    = 1'b1;
        cycles(1);
        check("reset_est", 32'(estadoJogo), 0);
        check("reset_regs", 32'(registradores), 0);
        check("reset_completo", 32'(completo), 0);
        check("reset_erro", 32'(erro), 0);
        reset_n = 1'b1;
        cycles(2);

        for (int i = 0; i < 17; i++) begin
            press(tab[i].op != 1, tab[i].op != 0, tab[i].sw);
            check($sformatf("vec%0d_est", i), 32'(estadoJogo), 32'(tab[i].est));
            check($sformatf("vec%0d_regs", i), 32'(registradores), 32'(tab[i].regs));
            check($sformatf("vec%0d_completo", i), 32'(completo), 32'(tab[i].est == N));
            check($sformatf("vec%0d_erro_cnt", i), 32'(erro_cnt), 32'(tab[i].errs));
        end
        m_err = erro_cnt;

        // Press-to-write latency: 2 + D + 2 cycles, +/-1.
        do_reset();
        switchCod   = 4'd3;
        btnConfirma = 1'b0;
        n = 0;
        while (estadoJogo == 3'd0 && n < 20) begin
            cycles(1);
            n++;
        end
        check("latency_window", 32'(n >= 2 + D + 1 && n <= 2 + D + 3), 1);
        btnConfirma = 1'b1;
        cycles(10);
        model_conf(3);
        check_model("latency_after");

        bounce_conf(4'd6, 1'b0);
        model_conf(6);
        check_model("bounce");

        // Reset while a confirm is mid-debounce.
        switchCod   = 4'd7;
        btnConfirma = 1'b0;
        cycles(3);
        reset_n = 1'b0;
        #1;
        check("midrst_est", 32'(estadoJogo), 0);
        check("midrst_regs", 32'(registradores), 0);
        check("midrst_completo", 32'(completo), 0);
        check("midrst_erro", 32'(erro), 0);
        cycles(2);
        reset_n = 1'b1;
        cycles(20);
        model_reset();
        check_model("held_no_pulse");
        btnConfirma = 1'b1;
        cycles(10);
        press(1'b1, 1'b0, 4'd7);
        model_conf(7);
        check_model("repress");

        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 19));
            v = 4'($urandom_range(0, 11));
            if (r < 11) begin
                press(1'b1, 1'b0, v);
                model_conf(int'(v));
            end else if (r < 16) begin
                press(1'b0, 1'b1, v);
                model_volta();
            end else if (r < 17) begin
                press(1'b1, 1'b1, v);
            end else begin
                bounce_conf(v, 1'b1);
                model_conf(int'(v));
            end
            check_model($sformatf("rnd%0d", it));
        end

        check("erro_single_cycle", 32'(erro_long), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
